// File: rtl/audio_dac_stream.sv
// ---------------------------------------------------------------------------
// audio_dac_stream
//
// Buffered I2S transmit stage for the WM8731 codec running as clock master.
// Stereo sample pairs arrive from game logic over a valid/ready handshake.
// They are queued in a small circular FIFO and then shifted out MSB-first on
// AUD_DACDAT. The codec-driven AUD_BCLK / AUD_DACLRCK set the timing, with
// the standard one-bit-clock I2S delay after each word-clock transition.
//
// Ports
//   CLOCK_50        in   system clock (50 MHz)
//   reset_n         in   asynchronous active-low reset
//   s_valid         in   sample pair offered
//   s_ready         out  FIFO can accept a pair (not full)
//   s_left          in   left sample, two's complement
//   s_right         in   right sample, two's complement
//   AUD_BCLK        in   codec bit clock, asynchronous to CLOCK_50
//   AUD_DACLRCK     in   codec DAC word clock, low = left, high = right
//   AUD_DACDAT      out  registered serial DAC data
//   fifo_level      out  number of pairs currently stored
//   underrun        out  sticky flag: FIFO was empty at a left-channel start
//   underrun_clear  in   clears underrun (a simultaneous new underrun wins)
// ---------------------------------------------------------------------------
module audio_dac_stream #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          CLOCK_50,
    input  logic                          reset_n,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [SAMPLE_WIDTH-1:0]       s_left,
    input  logic [SAMPLE_WIDTH-1:0]       s_right,
    input  logic                          AUD_BCLK,
    input  logic                          AUD_DACLRCK,
    output logic                          AUD_DACDAT,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underrun,
    input  logic                          underrun_clear
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(SAMPLE_WIDTH + 1);

    // Codec clock synchronizers; the third BCLK stage gives falling-edge detect
    logic bclk_s1_q, bclk_s2_q, bclk_s3_q;
    logic lrck_s1_q, lrck_s2_q;

    // FIFO state
    logic [2*SAMPLE_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]          level_q, level_d;

    // Serializer state
    logic                      locked_q, locked_d;
    logic                      lr_prev_q, lr_prev_d;
    logic                      active_q, active_d;
    logic [CNT_W-1:0]          bit_cnt_q, bit_cnt_d;
    logic [SAMPLE_WIDTH-1:0]   shift_q, shift_d;
    logic [SAMPLE_WIDTH-1:0]   hold_q, hold_d;
    logic                      dacdat_q, dacdat_d;
    logic                      underrun_q, underrun_d;

    logic                      fall;
    logic                      lrck;
    logic                      push;
    logic                      pop;
    logic                      fifo_empty;
    logic                      underrun_set;
    logic [2*SAMPLE_WIDTH-1:0] rd_pair;

    assign fall       = bclk_s3_q & ~bclk_s2_q;
    assign lrck       = lrck_s2_q;
    assign fifo_empty = (level_q == '0);
    assign s_ready    = (level_q != LVL_W'(FIFO_DEPTH));
    assign push       = s_valid & s_ready;
    assign rd_pair    = mem_q[rd_ptr_q];

    assign AUD_DACDAT = dacdat_q;
    assign fifo_level = level_q;
    assign underrun   = underrun_q;

    // Bring BCLK and LRCK into the CLOCK_50 domain. Both pass through the same
    // number of stages, so an LRCK change made on a BCLK falling edge shows up
    // in the same cycle as the detected fall.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            bclk_s1_q <= 1'b0;
            bclk_s2_q <= 1'b0;
            bclk_s3_q <= 1'b0;
            lrck_s1_q <= 1'b0;
            lrck_s2_q <= 1'b0;
        end else begin
            bclk_s1_q <= AUD_BCLK;
            bclk_s2_q <= bclk_s1_q;
            bclk_s3_q <= bclk_s2_q;
            lrck_s1_q <= AUD_DACLRCK;
            lrck_s2_q <= lrck_s1_q;
        end
    end

    // FIFO storage has no reset: reset only clears the pointers and level,
    // which is enough to discard whatever it held.
    always_ff @(posedge CLOCK_50) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {s_left, s_right};
        end
    end

    // Next-state logic for the FIFO bookkeeping and the serializer. Nothing in
    // the serializer moves except on a detected BCLK fall. The pop decision
    // uses the registered level, so a pair pushed in the same cycle as a left
    // start is too late to be played by it.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        locked_d     = locked_q;
        lr_prev_d    = lr_prev_q;
        active_d     = active_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        hold_d       = hold_q;
        dacdat_d     = dacdat_q;
        pop          = 1'b0;
        underrun_set = 1'b0;

        if (fall) begin
            if (!locked_q) begin
                // First edge after reset only learns the current word-clock
                // level so a half-finished frame is never played.
                locked_d  = 1'b1;
                lr_prev_d = lrck;
            end else if (lrck != lr_prev_q) begin
                // Channel start: this edge is the I2S delay slot, data is 0.
                lr_prev_d = lrck;
                bit_cnt_d = '0;
                active_d  = 1'b1;
                dacdat_d  = 1'b0;
                if (!lrck) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = rd_pair[2*SAMPLE_WIDTH-1:SAMPLE_WIDTH];
                        hold_d  = rd_pair[SAMPLE_WIDTH-1:0];
                    end else begin
                        shift_d      = '0;
                        hold_d       = '0;
                        underrun_set = 1'b1;
                    end
                end else begin
                    shift_d = hold_q;
                end
            end else if (active_q) begin
                dacdat_d  = shift_q[SAMPLE_WIDTH-1];
                shift_d   = {shift_q[SAMPLE_WIDTH-2:0], 1'b0};
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                if (bit_cnt_q == CNT_W'(SAMPLE_WIDTH - 1)) begin
                    active_d = 1'b0;
                end
            end else begin
                dacdat_d = 1'b0;
            end
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        // A fresh underrun takes priority over a clear in the same cycle.
        if (underrun_set) begin
            underrun_d = 1'b1;
        end else if (underrun_clear) begin
            underrun_d = 1'b0;
        end else begin
            underrun_d = underrun_q;
        end
    end

    // State registers; lr_prev resets high so the lock edge is what sets it.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            locked_q   <= 1'b0;
            lr_prev_q  <= 1'b1;
            active_q   <= 1'b0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            hold_q     <= '0;
            dacdat_q   <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            locked_q   <= locked_d;
            lr_prev_q  <= lr_prev_d;
            active_q   <= active_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            hold_q     <= hold_d;
            dacdat_q   <= dacdat_d;
            underrun_q <= underrun_d;
        end
    end

endmodule
